// File: rtl/mux2_4_arbiter.sv
// Two-requester round-robin arbiter with bounded burst, owning the select of a 2:1 mux
// and registering its result. Optional owner lock: define MUX2_4_ARB_LOCK_EN.
module mux2_4_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned BURST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
`ifdef MUX2_4_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] res,
    output logic             res_valid
);

    localparam logic [3:0] BurstC = 4'(BURST);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic             r_last;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_d;
    logic             r_sel;
    logic [WIDTH-1:0] r_res;
    logic             r_res_valid;

    logic             w_lock;
    logic             w_sat;
    logic             w_xfer;
    logic             w_win1;
    logic [WIDTH-1:0] w_mux;

`ifdef MUX2_4_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_sat = (r_cnt >= BurstC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d = StIdle;
        if (w_xfer) begin
            w_state_d = w_win1 ? StOwn1 : StOwn0;
        end
    end

    // Grant decision; gated by rst_n so nothing transfers while reset is held
    always_comb begin
        w_xfer = 1'b0;
        w_win1 = 1'b0;
        if (rst_n) begin
            if (req0 && req1) begin
                w_xfer = 1'b1;
                case (r_state)
                    StOwn0:  w_win1 = w_sat && !w_lock;
                    StOwn1:  w_win1 = !w_sat || w_lock;
                    default: w_win1 = !r_last;
                endcase
            end else if (req0 || req1) begin
                w_xfer = 1'b1;
                w_win1 = req1;
            end
        end
        gnt0 = w_xfer && !w_win1;
        gnt1 = w_xfer && w_win1;
    end

    assign w_mux = w_win1 ? in1 : in0;

    // Same owner as last transfer extends the burst; a new owner restarts at one
    always_comb begin
        w_cnt_d = 4'd0;
        if (w_xfer) begin
            if (r_state == w_state_d) begin
                w_cnt_d = w_sat ? BurstC : r_cnt + 4'd1;
            end else begin
                w_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_sel       <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_d;
            r_res_valid <= w_xfer;
            if (w_xfer) begin
                r_last <= w_win1;
                r_sel  <= w_win1;
                r_res  <= w_mux;
            end
        end
    end

    assign sel       = r_sel;
    assign res       = r_res;
    assign res_valid = r_res_valid;

endmodule

// File: tb/tb_mux2_4_arbiter.sv
// Directed self-checking bench for mux2_4_arbiter (WIDTH=4, BURST=2).
// Lock checks are compiled in when MUX2_4_ARB_LOCK_EN is defined.
module tb_mux2_4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] in0, in1;
    logic       gnt0, gnt1, sel, res_valid;
    logic [3:0] res;
`ifdef MUX2_4_ARB_LOCK_EN
    logic       lock;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux2_4_arbiter #(.WIDTH(4), .BURST(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .in0       (in0),
        .in1       (in1),
`ifdef MUX2_4_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .res       (res),
        .res_valid (res_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " gnt0"}, 32'(gnt0), 0);
        chk({tag, " gnt1"}, 32'(gnt1), 0);
        chk({tag, " res"}, 32'(res), 0);
        chk({tag, " res_valid"}, 32'(res_valid), 0);
        chk({tag, " sel"}, 32'(sel), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check async effect, release on a falling edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [5:0] seq;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        in0   = 4'd0;
        in1   = 4'd0;
`ifdef MUX2_4_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        #2;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_reset_vals("idle");
        end

        // Single requester streams every cycle
        req0 = 1'b1;
        in0  = 4'd8;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("solo gnt0", 32'(gnt0), 1);
            chk("solo gnt1", 32'(gnt1), 0);
            tick();
            chk("solo res", 32'(res), 8);
            chk("solo sel", 32'(sel), 0);
            chk("solo valid", 32'(res_valid), 1);
        end
        req0 = 1'b0;
        #1;
        chk("solo drop gnt0", 32'(gnt0), 0);
        tick();
        chk("solo drop valid", 32'(res_valid), 0);
        chk("solo drop res hold", 32'(res), 8);

        // Fresh reset so the first tie goes to requester 0
        do_reset("rst1");

        // Both requesting: bursts of two alternate, 0,0,1,1,0,0
        seq  = 6'b001100;
        req0 = 1'b1;
        req1 = 1'b1;
        in0  = 4'd7;
        in1  = 4'd3;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr gnt0", 32'(gnt0), 32'(!seq[5-i]));
            chk("rr gnt1", 32'(gnt1), 32'(seq[5-i]));
            tick();
            chk("rr res", 32'(res), seq[5-i] ? 3 : 7);
            chk("rr sel", 32'(sel), 32'(seq[5-i]));
            chk("rr valid", 32'(res_valid), 1);
        end

        // Idle, single requester-0 transfer, idle, then a tie goes to requester 1
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        req0 = 1'b1;
        #1;
        chk("brk gnt0", 32'(gnt0), 1);
        tick();
        chk("brk res", 32'(res), 7);
        req0 = 1'b0;
        tick();
        chk("brk idle valid", 32'(res_valid), 0);
        req0 = 1'b1;
        req1 = 1'b1;
        #1;
        chk("brk tie gnt1", 32'(gnt1), 1);
        chk("brk tie gnt0", 32'(gnt0), 0);
        tick();
        chk("brk tie res", 32'(res), 3);
        chk("brk tie sel", 32'(sel), 1);
        chk("brk tie valid", 32'(res_valid), 1);

        // Reset mid-burst while both request
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        chk_reset_vals("midrst held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst gnt0", 32'(gnt0), 1);
        chk("post rst gnt1", 32'(gnt1), 0);
        tick();
        chk("post rst res", 32'(res), 7);
        chk("post rst sel", 32'(sel), 0);

`ifdef MUX2_4_ARB_LOCK_EN
        // Lock keeps requester 0 past its burst; release hands over
        req0 = 1'b0;
        req1 = 1'b0;
        do_reset("rst lock");
        lock = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("lock gnt0", 32'(gnt0), 1);
            chk("lock gnt1", 32'(gnt1), 0);
            tick();
        end
        lock = 1'b0;
        #1;
        chk("unlock gnt1", 32'(gnt1), 1);
        tick();
        chk("unlock res", 32'(res), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
